// File: rtl/buffer_write_multi_flow.sv
// Write-side ingress of the multichannel buffer: maps flow-tagged AXI-stream beats
// onto free segments and publishes each filled or closed segment as a used pointer.
module buffer_write_multi_flow #(
    parameter int unsigned SEGMENT_SIZE_W = 10,
    parameter int unsigned BUF_SEG_AW     = 10,
    parameter int unsigned ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
    parameter int unsigned FLOWS_W        = 3,
    parameter int unsigned DATA_WIDTH     = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic [FLOWS_W-1:0]    s_tdest,
    output logic                  s_tready,
    input  logic                  fp_empty,
    output logic                  fp_rd_req,
    input  logic [BUF_SEG_AW-1:0] fp_rd_data,
    output logic                  b_wen,
    output logic [ADDR_WIDTH-1:0] b_waddr,
    output logic [DATA_WIDTH-1:0] b_wdata,
    output logic [BUF_SEG_AW:0]   used_pointer,
    output logic                  used_pointer_valid,
    output logic [FLOWS_W-1:0]    used_pointer_flow,
    output logic                  err_flow_change
);

    logic                      cur_valid, nxt_valid;
    logic [BUF_SEG_AW-1:0]     cur_ptr, nxt_ptr;
    logic                      req_outstanding;
    logic [SEGMENT_SIZE_W-1:0] offset;
    logic                      in_pkt;
    logic [FLOWS_W-1:0]        pkt_flow;

    logic                      cur_valid_n, nxt_valid_n;
    logic [BUF_SEG_AW-1:0]     cur_ptr_n, nxt_ptr_n;
    logic                      xfer_c, close_c, req_c;
    logic [FLOWS_W-1:0]        flow_c;

    assign xfer_c  = s_tvalid && cur_valid;
    assign close_c = xfer_c && (s_tlast || (offset == '1));
    assign flow_c  = in_pkt ? pkt_flow : s_tdest;
    // fp_rd_req and req_outstanding both block, so at most one pointer is ever in flight
    assign req_c   = (!cur_valid || !nxt_valid) && !fp_empty && !fp_rd_req && !req_outstanding;

    assign s_tready = cur_valid;
    assign b_wen    = xfer_c;
    assign b_waddr  = ADDR_WIDTH'({cur_ptr, offset});
    assign b_wdata  = s_tdata;

    // Slot update: promote nxt on close first, then drop the arriving pointer into the first hole
    always_comb begin
        cur_valid_n = cur_valid;
        cur_ptr_n   = cur_ptr;
        nxt_valid_n = nxt_valid;
        nxt_ptr_n   = nxt_ptr;
        if (close_c) begin
            cur_valid_n = nxt_valid;
            cur_ptr_n   = nxt_ptr;
            nxt_valid_n = 1'b0;
        end
        if (req_outstanding) begin
            if (!cur_valid_n) begin
                cur_valid_n = 1'b1;
                cur_ptr_n   = fp_rd_data;
            end else begin
                nxt_valid_n = 1'b1;
                nxt_ptr_n   = fp_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_valid          <= 1'b0;
            nxt_valid          <= 1'b0;
            cur_ptr            <= '0;
            nxt_ptr            <= '0;
            fp_rd_req          <= 1'b0;
            req_outstanding    <= 1'b0;
            offset             <= '0;
            in_pkt             <= 1'b0;
            pkt_flow           <= '0;
            err_flow_change    <= 1'b0;
            used_pointer       <= '0;
            used_pointer_valid <= 1'b0;
            used_pointer_flow  <= '0;
        end else begin
            cur_valid          <= cur_valid_n;
            nxt_valid          <= nxt_valid_n;
            cur_ptr            <= cur_ptr_n;
            nxt_ptr            <= nxt_ptr_n;
            fp_rd_req          <= req_c;
            req_outstanding    <= fp_rd_req;
            used_pointer_valid <= close_c;
            if (close_c) begin
                used_pointer      <= {s_tlast, cur_ptr};
                used_pointer_flow <= flow_c;
            end
            if (xfer_c) begin
                offset <= close_c ? '0 : offset + SEGMENT_SIZE_W'(1);
                in_pkt <= !s_tlast;
                if (!in_pkt) begin
                    pkt_flow <= s_tdest;
                end
                if (in_pkt && (s_tdest != pkt_flow)) begin
                    err_flow_change <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_buffer_write_multi_flow.sv
// Randomized and directed bench for buffer_write_multi_flow with a segment-level
// reference model and a behavioural free-pointer list.
module tb_buffer_write_multi_flow;

    localparam int unsigned SW  = 2;
    localparam int unsigned AW  = 10;
    localparam int unsigned FW  = 3;
    localparam int unsigned DW  = 64;
    localparam int unsigned ADW = AW + SW;

    logic           clk = 1'b0;
    logic           rstn;
    logic [DW-1:0]  s_tdata;
    logic           s_tvalid, s_tlast;
    logic [FW-1:0]  s_tdest;
    logic           s_tready;
    logic           fp_empty, fp_rd_req;
    logic [AW-1:0]  fp_rd_data;
    logic           b_wen;
    logic [ADW-1:0] b_waddr;
    logic [DW-1:0]  b_wdata;
    logic [AW:0]    used_pointer;
    logic           used_pointer_valid;
    logic [FW-1:0]  used_pointer_flow;
    logic           err_flow_change;

    always #5 clk = ~clk;

    buffer_write_multi_flow #(
        .SEGMENT_SIZE_W(SW), .BUF_SEG_AW(AW), .ADDR_WIDTH(ADW),
        .FLOWS_W(FW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdest(s_tdest),
        .s_tready(s_tready),
        .fp_empty(fp_empty), .fp_rd_req(fp_rd_req), .fp_rd_data(fp_rd_data),
        .b_wen(b_wen), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .used_pointer(used_pointer), .used_pointer_valid(used_pointer_valid),
        .used_pointer_flow(used_pointer_flow), .err_flow_change(err_flow_change)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the k-th segment ever opened uses the k-th pointer handed out
    logic [AW-1:0] fl[$];
    logic [AW-1:0] ptr_seq[$];
    logic [63:0]   exp_used[$];
    int            seg_idx;
    int            m_off;
    logic          exp_err;
    logic          prev_req;

    task automatic push_ptr(input logic [AW-1:0] p);
        fl.push_back(p);
        ptr_seq.push_back(p);
    endtask

    task automatic clear_model();
        fl.delete();
        ptr_seq.delete();
        exp_used.delete();
        seg_idx = 0;
        m_off   = 0;
        exp_err = 1'b0;
    endtask

    // Free-pointer list: answers a request with data valid in the following cycle
    always @(negedge clk) begin
        if (rstn && fp_rd_req) begin
            chk("fp_b2b", 64'(prev_req), 64'd0);
            if (fl.size() > 0) fp_rd_data = fl.pop_front();
            else chk("fp_req_when_empty", 64'd1, 64'd0);
        end
        prev_req = fp_rd_req;
        fp_empty = (fl.size() == 0);
    end

    always @(negedge clk) begin
        if (rstn && used_pointer_valid) begin
            if (exp_used.size() == 0) chk("used_extra", 64'd1, 64'd0);
            else chk("used_ptr", 64'({used_pointer_flow, used_pointer}), exp_used.pop_front());
        end
    end

    task automatic reset_dut();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic send_pkt(input int len, input logic [FW-1:0] flow, input int chg_beat,
                            input logic [FW-1:0] chg_flow, input int gap_pct, output int stalls);
        int  waited;
        bit  done;
        stalls = 0;
        for (int j = 0; j < len; j++) begin
            while (int'($urandom_range(99)) < gap_pct) @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            s_tlast  = (j == len - 1);
            s_tdest  = (chg_beat >= 0 && j >= chg_beat) ? chg_flow : flow;
            waited   = 0;
            done     = 1'b0;
            while (!done) begin
                #1;
                if (s_tready) begin
                    chk("b_wen", 64'(b_wen), 64'd1);
                    if (seg_idx < ptr_seq.size())
                        chk("b_waddr", 64'(b_waddr), 64'({ptr_seq[seg_idx], SW'(m_off)}));
                    else
                        chk("ptr_seq_underrun", 64'd0, 64'd1);
                    chk("b_wdata", b_wdata, s_tdata);
                    if (j > 0 && s_tdest != flow) exp_err = 1'b1;
                    if (s_tlast || m_off == (1 << SW) - 1) begin
                        exp_used.push_back(64'({flow, s_tlast, ptr_seq[seg_idx]}));
                        seg_idx++;
                        m_off = 0;
                    end else begin
                        m_off++;
                    end
                    done = 1'b1;
                end else begin
                    chk("b_wen_idle", 64'(b_wen), 64'd0);
                    stalls++;
                    waited++;
                    if (waited > 200) begin
                        chk("beat_timeout", 64'd0, 64'd1);
                        s_tvalid = 1'b0;
                        return;
                    end
                end
                @(negedge clk);
            end
            s_tvalid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_used.size() > 0; i++) @(negedge clk);
        chk("used_drain", 64'(exp_used.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit, finish required earlier");
        $fatal(1);
    end

    initial begin
        int st;
        int k;
        rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tdest = '0;
        fp_empty = 1'b1; fp_rd_data = '0; prev_req = 1'b0;
        clear_model();
        #2;
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_fp_req", 64'(fp_rd_req), 64'd0);
        chk("rst_wen", 64'(b_wen), 64'd0);
        chk("rst_used_valid", 64'(used_pointer_valid), 64'd0);
        chk("rst_err", 64'(err_flow_change), 64'd0);

        // 3-beat packet, flow 2, pointers 5,9
        reset_dut(); push_ptr(10'd5); push_ptr(10'd9);
        repeat (10) @(negedge clk);
        send_pkt(3, 3'd2, -1, 3'd0, 0, st);
        drain();

        // 6-beat packet crossing a segment boundary without backpressure
        reset_dut(); push_ptr(10'd5); push_ptr(10'd9);
        repeat (10) @(negedge clk);
        send_pkt(6, 3'd1, -1, 3'd0, 0, st);
        chk("boundary_stalls", 64'(st), 64'd0);
        drain();

        // Starvation: only one pointer for an 8-beat packet, second pushed later
        reset_dut(); push_ptr(10'd5);
        repeat (6) @(negedge clk);
        fork
            send_pkt(8, 3'd3, -1, 3'd0, 0, st);
            begin
                repeat (12) @(negedge clk);
                chk("starved_tready", 64'(s_tready), 64'd0);
                push_ptr(10'd7);
            end
        join
        drain();

        // Back-to-back single-beat packets each take a fresh segment
        reset_dut(); push_ptr(10'd4); push_ptr(10'd6);
        repeat (10) @(negedge clk);
        send_pkt(1, 3'd0, -1, 3'd0, 0, st);
        send_pkt(1, 3'd3, -1, 3'd0, 0, st);
        drain();

        // Flow change mid-packet raises a sticky error; used pointer keeps original flow
        reset_dut(); push_ptr(10'd3); push_ptr(10'd8); push_ptr(10'd12);
        repeat (10) @(negedge clk);
        send_pkt(3, 3'd1, 1, 3'd4, 0, st);
        drain();
        chk("err_set", 64'(err_flow_change), 64'(exp_err));
        send_pkt(2, 3'd5, -1, 3'd0, 0, st);
        drain();
        chk("err_sticky", 64'(err_flow_change), 64'd1);

        // Reset in the middle of a packet
        reset_dut(); push_ptr(10'd2); push_ptr(10'd3);
        repeat (10) @(negedge clk);
        s_tvalid = 1'b1; s_tdest = 3'd5; s_tlast = 1'b0; s_tdata = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_tready", 64'(s_tready), 64'd0);
        chk("midrst_fp_req", 64'(fp_rd_req), 64'd0);
        chk("midrst_wen", 64'(b_wen), 64'd0);
        chk("midrst_used", 64'({used_pointer_valid, used_pointer}), 64'd0);
        chk("midrst_err", 64'(err_flow_change), 64'd0);
        s_tvalid = 1'b0;
        clear_model();
        push_ptr(10'd11);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (fp_rd_req) break;
        end
        chk("req_after_rst", 64'(k <= 2), 64'd1);
        repeat (3) @(negedge clk);
        send_pkt(2, 3'd6, -1, 3'd0, 0, st);
        drain();

        // Randomized traffic
        reset_dut();
        for (int i = 0; i < 70; i++) push_ptr(AW'($urandom_range(1023)));
        repeat (5) @(negedge clk);
        for (int p = 0; p < 20; p++)
            send_pkt(int'($urandom_range(1, 9)), FW'($urandom_range(7)), -1, 3'd0, 30, st);
        drain();
        chk("rand_err", 64'(err_flow_change), 64'(exp_err));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
